// File: rtl/mem_arbiter.sv
// Two-requester (CPU / program loader) arbiter in front of a synchronous single-port RAM.
// Round-robin under contention; each transaction takes three cycles: IDLE, ACCESS, RESP.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    grant,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nx;
  logic          take;
  logic          win_ldr;
  logic          last_ldr;
  logic          own_ldr;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata_q;

  // Under contention the loader wins only if the CPU owned the previous transaction.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    win_ldr  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          take     = 1'b1;
          win_ldr  = ldr_req && (!cpu_req || !last_ldr);
          state_nx = ACCESS;
        end
      end
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Winner's request is captured once; inputs are ignored until the next IDLE sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_ldr  <= 1'b1;
      own_ldr   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (take) begin
        last_ldr  <= win_ldr;
        own_ldr   <= win_ldr;
        lat_we    <= win_ldr ? ldr_we    : cpu_we;
        lat_addr  <= win_ldr ? ldr_addr  : cpu_addr;
        lat_wdata <= win_ldr ? ldr_wdata : cpu_wdata;
      end
      if (state == RESP && !lat_we) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // RAM data arrives during RESP, so it is passed straight through alongside the ack.
  assign rdata     = (state == RESP && !lat_we) ? mem_rdata : rdata_q;
  assign grant     = (state == ACCESS || state == RESP) ? (own_ldr ? 2'b10 : 2'b01) : 2'b00;
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_ack   = (state == RESP) && !own_ldr;
  assign ldr_ack   = (state == RESP) && own_ldr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic against a
// transaction-level model (phase counter, round-robin pick, shadow memory).
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [7:0]  cpu_addr, ldr_addr;
  logic [15:0] cpu_wdata, ldr_wdata;
  logic        cpu_ack, ldr_ack;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  logic [15:0] ram   [0:255];
  logic [15:0] m_ram [0:255];

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.AW(8), .DW(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .rdata(rdata), .grant(grant),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 16'h0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h0; ldr_wdata = 16'h0;
  endtask

  // Random-phase model state
  int          ph;
  logic        m_last_ldr, m_own_ldr, m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
  int          nacks;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 3 + 16'h0100);
    idle_inputs();
    reset = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_grant",  32'(grant),     32'h0);
    chk("rst_cpuack", 32'(cpu_ack),   32'h0);
    chk("rst_ldrack", 32'(ldr_ack),   32'h0);
    chk("rst_memen",  32'(mem_en),    32'h0);
    chk("rst_memwe",  32'(mem_we),    32'h0);
    chk("rst_addr",   32'(mem_addr),  32'h0);
    chk("rst_wdata",  32'(mem_wdata), 32'h0);
    chk("rst_rdata",  32'(rdata),     32'h0);
    reset = 1'b1;

    // CPU-only read
    ram[8'h10] = 16'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick();
    chk("rd_memen",  32'(mem_en),   32'h1);
    chk("rd_memwe",  32'(mem_we),   32'h0);
    chk("rd_addr",   32'(mem_addr), 32'h10);
    chk("rd_grant1", 32'(grant),    32'h1);
    chk("rd_ack0",   32'(cpu_ack),  32'h0);
    cpu_req = 1'b0;
    tick();
    chk("rd_ack",    32'(cpu_ack),  32'h1);
    chk("rd_rdata",  32'(rdata),    32'h1234);
    chk("rd_grant2", 32'(grant),    32'h1);
    chk("rd_memen2", 32'(mem_en),   32'h0);
    tick();
    chk("rd_idle_grant", 32'(grant),   32'h0);
    chk("rd_idle_ack",   32'(cpu_ack), 32'h0);
    chk("rd_hold",       32'(rdata),   32'h1234);

    // Loader write then CPU read
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h05; ldr_wdata = 16'hBEEF;
    tick();
    chk("wr_grant", 32'(grant),     32'h2);
    chk("wr_memwe", 32'(mem_we),    32'h1);
    chk("wr_addr",  32'(mem_addr),  32'h05);
    chk("wr_wdata", 32'(mem_wdata), 32'hBEEF);
    ldr_req = 1'b0;
    tick();
    chk("wr_ack",    32'(ldr_ack), 32'h1);
    chk("wr_cpuack", 32'(cpu_ack), 32'h0);
    chk("wr_rdata",  32'(rdata),   32'h1234);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("rb_ack",   32'(cpu_ack), 32'h1);
    chk("rb_rdata", 32'(rdata),   32'hBEEF);
    tick();

    // Mid-flight input change is ignored
    ram[8'h20] = 16'h5555;
    cpu_req = 1'b1; cpu_addr = 8'h10;
    tick();
    cpu_addr = 8'h20; cpu_req = 1'b0;
    #1;
    chk("mf_addr", 32'(mem_addr), 32'h10);
    tick();
    chk("mf_rdata", 32'(rdata), 32'h1234);
    tick();

    // One-cycle request pulse still completes exactly once
    cpu_req = 1'b1; cpu_addr = 8'h05;
    tick();
    cpu_req = 1'b0;
    nacks = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      nacks += int'(cpu_ack);
    end
    chk("pulse_acks", 32'(nacks), 32'h1);

    // Contention from reset: CPU first, then strict alternation
    reset = 1'b0;
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h05;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int idx, p;
      tick();
      idx = (k - 1) / 3;
      p   = (k - 1) % 3;
      chk("ct_grant",  32'(grant),   (p == 2) ? 32'h0 : ((idx % 2 == 0) ? 32'h1 : 32'h2));
      chk("ct_cpuack", 32'(cpu_ack), 32'((p == 1) && (idx % 2 == 0)));
      chk("ct_ldrack", 32'(ldr_ack), 32'((p == 1) && (idx % 2 == 1)));
    end
    idle_inputs();
    tick(); tick(); tick();

    // Reset during ACCESS of a loader write
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h07; ldr_wdata = 16'h7777;
    tick();
    chk("ra_grant_pre", 32'(grant), 32'h2);
    ldr_req = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("ra_grant", 32'(grant),     32'h0);
    chk("ra_memen", 32'(mem_en),    32'h0);
    chk("ra_memwe", 32'(mem_we),    32'h0);
    chk("ra_addr",  32'(mem_addr),  32'h0);
    chk("ra_wdata", 32'(mem_wdata), 32'h0);
    chk("ra_rdata", 32'(rdata),     32'h0);
    chk("ra_ack",   32'(ldr_ack),   32'h0);
    tick();
    chk("ra_ack2",  32'(ldr_ack),   32'h0);
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h05;
    tick();
    chk("ra_cpu_wins", 32'(grant), 32'h1);
    idle_inputs();
    tick(); tick(); tick();

    // Random traffic against transaction-level model
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) m_ram[i] = ram[i];
    ph = 0; m_last_ldr = 1'b1; m_own_ldr = 1'b0; m_we = 1'b0;
    m_addr = 8'h0; m_wdata = 16'h0; m_rdata = 16'h0;
    for (int n = 0; n < 400; n++) begin
      cpu_req   = ($urandom_range(0, 1) == 1);
      cpu_we    = ($urandom_range(0, 2) == 0);
      cpu_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      ldr_req   = ($urandom_range(0, 1) == 1);
      ldr_we    = ($urandom_range(0, 1) == 0);
      ldr_addr  = 8'($urandom_range(0, 15));
      ldr_wdata = 16'($urandom);
      if (ph == 0) begin
        if (cpu_req || ldr_req) begin
          m_own_ldr  = ldr_req && (!cpu_req || !m_last_ldr);
          m_last_ldr = m_own_ldr;
          m_we    = m_own_ldr ? ldr_we    : cpu_we;
          m_addr  = m_own_ldr ? ldr_addr  : cpu_addr;
          m_wdata = m_own_ldr ? ldr_wdata : cpu_wdata;
          ph = 1;
        end
      end else if (ph == 1) begin
        if (m_we) m_ram[m_addr] = m_wdata;
        else      m_rdata = m_ram[m_addr];
        ph = 2;
      end else begin
        ph = 0;
      end
      tick();
      chk("rn_grant",  32'(grant),   (ph == 0) ? 32'h0 : (m_own_ldr ? 32'h2 : 32'h1));
      chk("rn_memen",  32'(mem_en),  32'(ph == 1));
      chk("rn_cpuack", 32'(cpu_ack), 32'(ph == 2 && !m_own_ldr));
      chk("rn_ldrack", 32'(ldr_ack), 32'(ph == 2 && m_own_ldr));
      chk("rn_rdata",  32'(rdata),   32'(m_rdata));
      if (ph == 1) begin
        chk("rn_memwe", 32'(mem_we),   32'(m_we));
        chk("rn_addr",  32'(mem_addr), 32'(m_addr));
        if (m_we) chk("rn_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
